// File: rtl/mem_access_unit.sv
// Memory-access stage controller: turns loads/stores into a req/ack transaction on the
// data-memory port and formats load data into a registered result for ME_WB.
module mem_access_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_read_in,
    input  logic        mem_write_in,
    input  logic [2:0]  funct3_in,
    input  logic [31:0] alu_result_in,
    input  logic [31:0] rs2_data_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic [31:0] mem_data_out,
    output logic        stall_out,
    output logic        misalign_out
);

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StDone
    } state_e;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  lane_q, lane_d;
    logic [2:0]  funct3_q, funct3_d;
    logic        misalign_q, misalign_d;
    logic [31:0] mem_data_q, mem_data_d;

    logic        start;
    logic        bad;
    logic        is_store;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // A request with both read and write set is treated as a store.
    assign is_store = mem_write_in;
    assign start    = (state_q == StIdle) && valid_in && (mem_read_in || mem_write_in);

    always_comb begin
        bad = 1'b0;
        unique case (funct3_in)
            3'b000, 3'b100: bad = 1'b0;
            3'b001, 3'b101: bad = alu_result_in[0];
            3'b010:         bad = (alu_result_in[1:0] != 2'b00);
            default:        bad = 1'b1;
        endcase
    end

    always_comb begin
        st_be    = 4'b0000;
        st_wdata = 32'h0;
        unique case (funct3_in[1:0])
            2'b00: begin
                st_be    = 4'b0001 << alu_result_in[1:0];
                st_wdata = {4{rs2_data_in[7:0]}};
            end
            2'b01: begin
                st_be    = alu_result_in[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{rs2_data_in[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = rs2_data_in;
            end
        endcase
    end

    always_comb begin
        ld_byte = 8'h0;
        unique case (lane_q)
            2'b00: ld_byte = dmem_rdata[7:0];
            2'b01: ld_byte = dmem_rdata[15:8];
            2'b10: ld_byte = dmem_rdata[23:16];
            default: ld_byte = dmem_rdata[31:24];
        endcase
        ld_half = lane_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

        ld_data = dmem_rdata;
        unique case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b100:  ld_data = {24'h0, ld_byte};
            3'b101:  ld_data = {16'h0, ld_half};
            default: ld_data = dmem_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        lane_d     = lane_q;
        funct3_d   = funct3_q;
        misalign_d = 1'b0;
        mem_data_d = mem_data_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (bad) begin
                        misalign_d = 1'b1;
                    end else begin
                        we_d     = is_store;
                        addr_d   = {alu_result_in[31:2], 2'b00};
                        be_d     = is_store ? st_be : 4'b0000;
                        wdata_d  = is_store ? st_wdata : 32'h0;
                        lane_d   = alu_result_in[1:0];
                        funct3_d = funct3_in;
                        state_d  = StReq;
                    end
                end
            end
            StReq: begin
                if (dmem_ack) begin
                    if (!we_q) begin
                        mem_data_d = ld_data;
                    end
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            we_q       <= 1'b0;
            addr_q     <= 32'h0;
            be_q       <= 4'b0000;
            wdata_q    <= 32'h0;
            lane_q     <= 2'b00;
            funct3_q   <= 3'b000;
            misalign_q <= 1'b0;
            mem_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            lane_q     <= lane_d;
            funct3_q   <= funct3_d;
            misalign_q <= misalign_d;
            mem_data_q <= mem_data_d;
        end
    end

    // Request is decoded straight from the state flop so reset removes it at once.
    assign dmem_req     = (state_q == StReq);
    assign dmem_we      = we_q;
    assign dmem_addr    = addr_q;
    assign dmem_be      = be_q;
    assign dmem_wdata   = wdata_q;
    assign mem_data_out = mem_data_q;
    assign misalign_out = misalign_q;
    assign stall_out    = (start && !bad) || (state_q == StReq);

endmodule
